rr_arbiter8: RTL

- Round-robin arbiter that shares one resource between 8 requesters.
- Produces a registered one-hot grant vector and its 3-bit binary index (the one-hot-to-binary encoding used across the datapath).
- Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits in front of any shared unit (bus slot, encoder/ALU port) that accepts one master at a time.

---
 rtl/rr_arbiter8.sv | 112 +++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, binary index,
// hold-limit revoke and a guaranteed idle cycle between successive grants.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [7:0]       grant_nxt;
  logic [2:0]       idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  logic [2:0]       sel;
  logic [2:0]       cand;
  logic             sel_found;
  logic             release_now;
  logic             hold_expired;

  // First set request at or above the pointer, wrapping 7 -> 0.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!sel_found && req[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign release_now  = done || !req[grant_idx];
  assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    grant_nxt   = '0;
    idx_nxt     = '0;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt = 8'b1 << sel;
          idx_nxt   = sel;
          valid_nxt = 1'b1;
          hold_nxt  = CNT_W'(1);
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        // Release outranks revoke, so a done on the last allowed cycle is not a timeout.
        if (release_now || hold_expired) begin
          hold_nxt    = '0;
          ptr_nxt     = grant_idx + 3'd1;
          state_nxt   = IDLE;
          timeout_nxt = !release_now;
        end else begin
          grant_nxt = grant;
          idx_nxt   = grant_idx;
          valid_nxt = 1'b1;
          hold_nxt  = hold_cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule
